// File: rtl/pdm_pkg.sv
// Shared constants for the multi-channel pulse-density modulator.
package pdm_pkg;

  localparam logic MODE_PDM = 1'b0;
  localparam logic MODE_PWM = 1'b1;

  function automatic int unsigned frame_len(input int unsigned width);
    return 32'd1 << width;
  endfunction

endpackage

// File: rtl/pdm_channel.sv
// One modulator lane: double-buffered level, sigma-delta accumulator and output flop.
module pdm_channel
  import pdm_pkg::*;
#(
  parameter int WIDTH       = 5,
  parameter bit SYNC_UPDATE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [WIDTH-1:0] frame_cnt_i,
  input  logic             commit_i,
  input  logic             clear_acc_i,
  input  logic             mode_i,
  output logic             out_o,
  output logic             pending_o
);

  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             pending_q, pending_d;
  logic             out_q, out_d;
  logic [WIDTH:0]   sum;

  always_comb begin
    pend_d    = pend_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (SYNC_UPDATE) begin
      // Commit the value held before this edge; a simultaneous write re-arms pending.
      if (commit_i && pending_q) begin
        active_d  = pend_q;
        pending_d = 1'b0;
      end
      if (write_i) begin
        pend_d    = data_i;
        pending_d = 1'b1;
      end
    end else if (write_i) begin
      pend_d   = data_i;
      active_d = data_i;
    end

    sum = {1'b0, acc_q} + {1'b0, active_q};
    if (mode_i == MODE_PWM) begin
      acc_d = '0;
      out_d = (frame_cnt_i < active_q);
    end else begin
      acc_d = sum[WIDTH-1:0];
      out_d = sum[WIDTH];
    end
    if (clear_acc_i) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q    <= '0;
      active_q  <= '0;
      acc_q     <= '0;
      pending_q <= 1'b0;
      out_q     <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      active_q  <= active_d;
      acc_q     <= acc_d;
      pending_q <= pending_d;
      out_q     <= out_d;
    end
  end

  assign out_o     = out_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/pdm_multi_channel.sv
// Multi-channel PDM/PWM modulator: shared frame counter, commit strobe and mode register
// driving one pdm_channel per output.
module pdm_multi_channel
  import pdm_pkg::*;
#(
  parameter int WIDTH       = 5,
  parameter int CHANNELS    = 3,
  parameter bit SYNC_UPDATE = 1'b1,
  localparam int AW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                write_en,
  input  logic [AW-1:0]       write_addr,
  input  logic [WIDTH-1:0]    write_data,
  input  logic                mode,
  output logic [CHANNELS-1:0] pdm_out,
  output logic                frame_start,
  output logic [CHANNELS-1:0] pending
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(frame_len(WIDTH) - 1);

  logic [WIDTH-1:0]    frame_cnt_q, frame_cnt_d;
  logic                frame_start_q, frame_start_d;
  logic                mode_q, mode_d;
  logic                commit;
  logic                clear_acc;
  logic [CHANNELS-1:0] ch_write;

  assign commit = (frame_cnt_q == CNT_MAX);

  always_comb begin
    frame_cnt_d   = frame_cnt_q + WIDTH'(1);
    frame_start_d = commit;
    mode_d        = commit ? mode : mode_q;
    // A mode switch restarts every accumulator so the new encoding begins cleanly.
    clear_acc     = commit && (mode != mode_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_q   <= '0;
      frame_start_q <= 1'b0;
      mode_q        <= MODE_PDM;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      frame_start_q <= frame_start_d;
      mode_q        <= mode_d;
    end
  end

  assign frame_start = frame_start_q;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    assign ch_write[gi] = write_en && (write_addr == AW'(gi));

    pdm_channel #(
      .WIDTH      (WIDTH),
      .SYNC_UPDATE(SYNC_UPDATE)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .write_i    (ch_write[gi]),
      .data_i     (write_data),
      .frame_cnt_i(frame_cnt_q),
      .commit_i   (commit),
      .clear_acc_i(clear_acc),
      .mode_i     (mode_q),
      .out_o      (pdm_out[gi]),
      .pending_o  (pending[gi])
    );
  end

endmodule

// File: tb/tb_pdm_multi_channel.sv
// Scoreboard bench for pdm_multi_channel: a frame-level reference model predicts every output cycle.
module tb_pdm_multi_channel;

  localparam int W  = 5;
  localparam int N  = 3;
  localparam int FL = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         write_en = 1'b0;
  logic [1:0]   write_addr = '0;
  logic [W-1:0] write_data = '0;
  logic         mode = 1'b0;
  logic [N-1:0] pdm_out;
  logic         frame_start;
  logic [N-1:0] pending;

  pdm_multi_channel #(.WIDTH(W), .CHANNELS(N), .SYNC_UPDATE(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .mode       (mode),
    .pdm_out    (pdm_out),
    .frame_start(frame_start),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]        pdm;
    logic [N-1:0]        pnd;
    logic                fs;
    int                  k;
    logic                pwm;
    logic [N-1:0][W-1:0] lvl;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  // Reference state: level/mode in force for the current frame and the write buffer.
  int       m_pos;
  int       m_pend[N];
  int       m_active[N];
  logic [N-1:0] m_pending;
  logic     m_mode;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // Bit k of a frame at constant level lvl, accumulator starting at zero.
  function automatic bit frame_bit(input bit pwm, input int lvl, input int k);
    if (pwm) return k < lvl;
    return (((k + 1) * lvl) / FL - (k * lvl) / FL) != 0;
  endfunction

  initial begin : model
    exp_t e;
    m_pos = 0; m_pending = '0; m_mode = 1'b0;
    for (int ch = 0; ch < N; ch++) begin m_pend[ch] = 0; m_active[ch] = 0; end
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_pos = 0; m_pending = '0; m_mode = 1'b0;
        for (int ch = 0; ch < N; ch++) begin m_pend[ch] = 0; m_active[ch] = 0; end
        sb.delete();
      end else begin
        e.k = m_pos;
        e.pwm = m_mode;
        for (int ch = 0; ch < N; ch++) begin
          e.pdm[ch] = frame_bit(m_mode, m_active[ch], m_pos);
          e.lvl[ch] = W'(m_active[ch]);
        end
        if (m_pos == FL - 1) begin
          for (int ch = 0; ch < N; ch++)
            if (m_pending[ch]) begin m_active[ch] = m_pend[ch]; m_pending[ch] = 1'b0; end
          m_mode = mode;
        end
        if (write_en && write_addr < N) begin
          m_pend[write_addr] = int'(write_data);
          m_pending[write_addr] = 1'b1;
        end
        e.pnd = m_pending;
        e.fs = (m_pos == FL - 1);
        m_pos = (m_pos + 1) % FL;
        sb.push_back(e);
      end
    end
  end

  initial begin : monitor
    exp_t e;
    int ones[N];
    int run[N];
    int maxrun[N];
    forever begin
      @(negedge clk);
      if (reset || sb.size() == 0) continue;
      e = sb.pop_front();
      if (e.k == 0)
        for (int ch = 0; ch < N; ch++) begin ones[ch] = 0; run[ch] = 0; maxrun[ch] = 0; end
      chk("pdm_out", int'(pdm_out), int'(e.pdm));
      chk("pending", int'(pending), int'(e.pnd));
      chk("frame_start", int'(frame_start), int'(e.fs));
      for (int ch = 0; ch < N; ch++) begin
        if (pdm_out[ch]) begin
          ones[ch]++; run[ch]++;
          if (run[ch] > maxrun[ch]) maxrun[ch] = run[ch];
        end else run[ch] = 0;
      end
      if (e.k == FL - 1) begin
        for (int ch = 0; ch < N; ch++) begin
          int l;
          l = int'(e.lvl[ch]);
          chk($sformatf("ones_per_frame ch%0d", ch), ones[ch], l);
          if (!e.pwm && l > 0 && l < FL)
            chk($sformatf("run_bound ch%0d", ch), int'(maxrun[ch] <= (l + FL - l - 1) / (FL - l)), 1);
        end
      end
    end
  end

  task automatic wait_pos(input int pos);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (m_pos != pos && n < 2 * FL);
    if (m_pos != pos) chk("wait_pos timeout", m_pos, pos);
  endtask

  task automatic write_at(input int pos, input int a, input int d);
    wait_pos(pos);
    write_en = 1'b1; write_addr = 2'(a); write_data = W'(d);
    $display("write ch=%0d data=%0d at frame pos %0d mode=%0d", a, d, pos, mode);
    @(negedge clk);
    write_en = 1'b0;
  endtask

  task automatic set_mode_at(input int pos, input bit v);
    wait_pos(pos);
    mode = v;
    $display("mode=%0d at frame pos %0d", v, pos);
  endtask

  initial begin : stim
    int n;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Load some levels, then reset mid-frame with a write pending.
    write_at(4, 2, 31);
    repeat (FL) @(negedge clk);
    write_at(3, 1, 5);
    wait_pos(6);
    #2 reset = 1'b1;
    #1;
    chk("reset pdm_out", int'(pdm_out), 0);
    chk("reset pending", int'(pending), 0);
    chk("reset frame_start", int'(frame_start), 0);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_start && n < 40);
    chk("first frame_start edges", n, FL);
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_start && n < 40);
    chk("frame_start period", n, FL);

    // PDM levels, including the extremes.
    write_at(10, 0, 8);
    write_at(12, 2, 31);
    write_at(14, 1, 0);
    repeat (2 * FL) @(negedge clk);

    // PWM on ch1.
    set_mode_at(5, 1'b1);
    write_at(8, 1, 26);
    repeat (2 * FL) @(negedge clk);

    // Write landing on the commit edge while another level is pending.
    write_at(3, 2, 4);
    write_at(31, 2, 15);
    repeat (2 * FL) @(negedge clk);

    // Out-of-range channel.
    write_at(7, 3, 31);
    repeat (FL) @(negedge clk);

    // Mode toggles mid-frame.
    set_mode_at(16, 1'b0);
    repeat (2 * FL) @(negedge clk);
    set_mode_at(20, 1'b1);
    repeat (FL) @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      int a, d, p;
      a = $urandom_range(0, 3);
      d = $urandom_range(0, FL - 1);
      p = ($urandom_range(0, 3) == 0) ? FL - 1 : $urandom_range(0, FL - 1);
      if ($urandom_range(0, 4) == 0) set_mode_at($urandom_range(0, FL - 1), 1'($urandom_range(0, 1)));
      write_at(p, a, d);
    end
    repeat (2 * FL + 2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
